down_timer: RTL and testbench
=============================

Name: down_timer

Overview:
Loadable down-counting timer, the counterpart to the team's enabled up-counter. It counts from a loaded value toward zero and flags terminal count. One-shot or auto-reload mode. Used as a programmable delay or period generator next to the up-counter in the sequential-circuits library.

Parameters:
WIDTH, 4, bit width of the count, load value and reload register.

Ports:
clock  input  1  rising-edge system clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
enable  input  1  count permitted this cycle when high
load  input  1  capture load_value this cycle; priority over enable
load_value  input  WIDTH  start/reload value
auto_reload  input  1  1 = periodic mode, 0 = one-shot; sampled every cycle
counter_out  output  WIDTH  current count (registered)
busy  output  1  high while in RUN
done  output  1  high while in DONE
tc  output  1  one-cycle pulse on terminal count

Behaviour:
- Reset (reset low, asynchronous): counter_out=0, reload_reg=0, state=IDLE, busy=0, done=0, tc=0. All outputs are held until the first rising edge after reset is released.
- All outputs are registered. busy and done decode the state register.
- States: IDLE (no count loaded), RUN (counting), DONE (one-shot expired).
- Any state, load=1:
  - counter_out<=load_value and reload_reg<=load_value.
  - If load_value!=0, next state is RUN. If load_value==0, next state is IDLE.
  - tc<=0. load overrides enable and any same-cycle terminal count, so no tc pulse.
- RUN, load=0, enable=0: hold counter_out and state. tc<=0.
- RUN, load=0, enable=1, counter_out>1: counter_out<=counter_out-1. tc<=0.
- RUN, load=0, enable=1, counter_out==1 (terminal count): tc<=1 for exactly one cycle.
  - auto_reload=1: counter_out<=reload_reg, stay in RUN. Period = reload_reg enabled cycles.
  - auto_reload=0: counter_out<=0, go to DONE.
- DONE: counter_out holds 0, done=1, enable is ignored. Only load or reset leaves DONE.
- IDLE: counter_out holds its value, enable is ignored, tc=0.
- No underflow: the decrement path is only taken when counter_out>=2. counter_out never wraps to all-ones.
- Max load (2^WIDTH-1): full range counts without overflow, since the block only subtracts.
- Reset asserted mid-count: immediately returns to the reset values, including reload_reg. A subsequent auto-reload requires a new load.
- Toggling auto_reload during RUN takes effect at the next terminal count only.

Decomposition:
- Shared package/include holds the state encoding constants: IDLE=2'b00, RUN=2'b01, DONE=2'b10, plus the default WIDTH.
- Single module, no sub-module. The next-state/next-count logic is one combinational block feeding one registered block.

Test Plan:
1. Async reset: hold reset=0 mid-cycle with a non-zero count -> counter_out=0, busy=0, done=0, tc=0 immediately, without waiting for a clock edge.
2. One-shot: load 5, then enable=1, auto_reload=0 -> counter_out sequence 5,4,3,2,1,0. tc high only on the cycle counter_out becomes 0. done=1 from then on. Further enable leaves counter_out at 0.
3. Auto-reload: load 3, auto_reload=1, enable held high -> sequence 3,2,1,3,2,1,3. tc pulses every 3rd cycle. busy stays 1.
4. Enable gating: load 4, then enable pattern 1,0,0,1 -> counter_out sequence 4,3,3,3,2. tc=0 throughout.
5. Load priority: at counter_out==1 with enable=1, assert load with load_value=9 -> counter_out=9, tc stays 0, state RUN. Separately, load 0 -> state IDLE, busy=0.
6. Full range (WIDTH=4): load 15, auto_reload=0, enable high -> 15 down to 0 in 15 enabled cycles, no wrap to 15. Single tc pulse.

Source files
------------

// File: rtl/down_timer_pkg.sv
// Shared definitions for the loadable down-counting timer: state encoding,
// default count width and a small helper used by the next-state logic.
package down_timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // A loaded value of zero has nothing to count, so it parks the timer in IDLE.
  function automatic state_e load_target(input logic nonzero);
    return nonzero ? RUN : IDLE;
  endfunction

endpackage

// File: rtl/down_timer.sv
// Loadable down-counting timer with terminal-count pulse, one-shot or
// auto-reload operation. One combinational next-state block, one register block.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] counter_out,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  // state | meaning
  // IDLE  | no count loaded; counter holds, enable ignored
  // RUN   | counting down on enabled cycles
  // DONE  | one-shot expired; counter at zero until next load

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      state_d  = load_target(load_value != '0);
    end else begin
      case (state_q)
        RUN: begin
          if (enable) begin
            // Decrement only from 2 upward, so the count can never wrap.
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else if (count_q == ONE) begin
              tc_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = DONE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign counter_out = count_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign tc          = tc_q;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios followed by random
// stimulus, all compared against a behavioural timer model.
module tb_down_timer;

  localparam int W = 4;

  logic         clock;
  logic         reset;
  logic         enable;
  logic         load;
  logic [W-1:0] load_value;
  logic         auto_reload;
  logic [W-1:0] counter_out;
  logic         busy;
  logic         done;
  logic         tc;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: remaining count, remembered period and two flags.
  int m_count;
  int m_period;
  bit m_counting;
  bit m_expired;
  bit m_tc;

  down_timer #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .auto_reload(auto_reload),
    .counter_out(counter_out),
    .busy       (busy),
    .done       (done),
    .tc         (tc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count    = 0;
    m_period   = 0;
    m_counting = 0;
    m_expired  = 0;
    m_tc       = 0;
  endtask

  task automatic model_step(input bit en, input bit ld, input int lv, input bit ar);
    m_tc = 0;
    if (ld) begin
      m_count    = lv;
      m_period   = lv;
      m_counting = (lv != 0);
      m_expired  = 0;
    end else if (m_counting && en) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        m_tc = 1;
        if (ar) m_count = m_period;
        else begin
          m_counting = 0;
          m_expired  = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, int'(counter_out), m_count);
    chk({tag, ".busy"},  int'(busy),        int'(m_counting));
    chk({tag, ".done"},  int'(done),        int'(m_expired));
    chk({tag, ".tc"},    int'(tc),          int'(m_tc));
  endtask

  // Inputs are applied at edge+1 and held across the next rising edge.
  task automatic cycle(input string tag, input bit en, input bit ld, input int lv, input bit ar);
    enable      = en;
    load        = ld;
    load_value  = W'(lv);
    auto_reload = ar;
    @(posedge clock);
    model_step(en, ld, lv, ar);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset_pulse(input string tag);
    #3 reset = 1'b0;
    model_reset();
    #1;
    chk({tag, ".rst_count"}, int'(counter_out), 0);
    chk({tag, ".rst_busy"},  int'(busy),        0);
    chk({tag, ".rst_done"},  int'(done),        0);
    chk({tag, ".rst_tc"},    int'(tc),          0);
    #1 reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    enable      = 1'b0;
    load        = 1'b0;
    load_value  = '0;
    auto_reload = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all("por");
    #3 reset = 1'b1;
    @(posedge clock);
    #1;
    check_all("post_rel");

    // Async reset mid-count, then confirm reload value was also cleared.
    cycle("ar_ld", 0, 1, 7, 1);
    cycle("ar_run", 1, 0, 0, 1);
    async_reset_pulse("async");
    cycle("ar_after", 1, 0, 0, 1);

    // One-shot from 5, with extra enabled cycles after expiry.
    cycle("os_ld", 0, 1, 5, 0);
    for (int i = 0; i < 7; i++) cycle("oneshot", 1, 0, 0, 0);

    // Auto-reload period 3.
    cycle("rl_ld", 0, 1, 3, 1);
    for (int i = 0; i < 7; i++) cycle("reload", 1, 0, 0, 1);

    // Enable gating 1,0,0,1 from 4.
    cycle("eg_ld", 0, 1, 4, 0);
    cycle("gate", 1, 0, 0, 0);
    cycle("gate", 0, 0, 0, 0);
    cycle("gate", 0, 0, 0, 0);
    cycle("gate", 1, 0, 0, 0);

    // Load beats a same-cycle terminal count; then load zero parks in IDLE.
    cycle("lp_ld", 0, 1, 2, 0);
    cycle("lp_dec", 1, 0, 0, 0);
    cycle("lp_prio", 1, 1, 9, 0);
    cycle("lp_hold", 0, 0, 0, 0);
    cycle("lp_zero", 1, 1, 0, 1);
    cycle("lp_idle", 1, 0, 0, 1);

    // Full range from 15, one-shot, with no wrap afterward.
    cycle("fr_ld", 0, 1, 15, 0);
    for (int i = 0; i < 18; i++) cycle("full", 1, 0, 0, 0);

    // Auto-reload toggled mid-run only matters at terminal count.
    cycle("tg_ld", 0, 1, 4, 0);
    cycle("toggle", 1, 0, 0, 0);
    cycle("toggle", 1, 0, 0, 1);
    cycle("toggle", 1, 0, 0, 0);
    cycle("toggle", 1, 0, 0, 1);
    cycle("toggle", 1, 0, 0, 1);

    // Random traffic, with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      bit en, ld, ar;
      int lv;
      en = ($urandom_range(0, 99) < 75);
      ld = ($urandom_range(0, 99) < 8);
      ar = ($urandom_range(0, 99) < 50);
      case ($urandom_range(0, 3))
        0:       lv = 0;
        1:       lv = 1;
        2:       lv = 15;
        default: lv = $urandom_range(0, 15);
      endcase
      cycle("rand", en, ld, lv, ar);
      if ($urandom_range(0, 199) == 0) async_reset_pulse("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
